id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RV32I core.
- Captures decoded operands and control from ID and presents them to EX and the EX-stage operand forwarding unit (ex_rs1/rs2 addr/val).
- Detects load-use hazards and inserts a bubble; applies branch flush and downstream hold.
- Bypasses same-cycle WB writes into captured operands and counts load-use stall cycles.

Parameters:
- XLEN, 32, datapath width
- CNT_W, 16, width of the saturating stall-cycle counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of the ID instruction
- id_imm  in  XLEN  decoded immediate
- id_rs1_addr  in  5  source register 1 index
- id_rs2_addr  in  5  source register 2 index
- id_use_rs1  in  1  instruction reads rs1
- id_use_rs2  in  1  instruction reads rs2
- id_rs1_val  in  XLEN  register file read data for rs1
- id_rs2_val  in  XLEN  register file read data for rs2
- id_rd_addr  in  5  destination register
- id_reg_write  in  1  writes rd
- id_mem_read  in  1  load
- id_mem_write  in  1  store
- id_alu_op  in  4  ALU operation code
- wb_reg_write  in  1  WB writes the register file this cycle
- wb_rd_addr  in  5  WB destination register
- wb_rd_val  in  XLEN  WB write data
- ex_branch_taken  in  1  EX redirect; flush the younger instruction
- hold  in  1  downstream (MEM) freeze
- ex_valid  out  1  EX holds a real instruction
- ex_pc, ex_imm  out  XLEN  registered copies
- ex_rs1_addr, ex_rs2_addr  out  5  registered source indices
- ex_rs1_val, ex_rs2_val  out  XLEN  registered operands, WB-bypassed
- ex_rd_addr  out  5  registered destination
- ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control
- ex_alu_op  out  4  registered ALU op
- stall  out  1  combinational; freezes PC and IF/ID this cycle
- stall_cnt  out  CNT_W  load-use stall cycles, saturating

Behaviour:
- Reset (async, rst_n=0): all ex_* outputs 0 (bubble); stall_cnt=0. stall is combinational from hold and the hazard term, and therefore 0 whenever ex_valid=0 and hold=0.
- lu_hazard = id_valid & ex_valid & ex_mem_read & ex_rd_addr!=0 & ((id_use_rs1 & id_rs1_addr==ex_rd_addr) | (id_use_rs2 & id_rs2_addr==ex_rd_addr)).
- Per-edge priority, highest first:
  1. hold=1: all ex_* registers keep their values; stall=1; counter unchanged.
  2. ex_branch_taken=1: load a bubble; stall=0, even if lu_hazard=1.
  3. lu_hazard=1: load a bubble; stall=1; stall_cnt += 1, saturating at all-ones.
  4. Otherwise: capture all id_* fields; ex_valid=id_valid; stall=0.
- Bubble: every ex_* output becomes 0, including addresses, so the forwarding unit resolves operands to x0.
- id_valid=0 with normal capture: the registered control (reg_write, mem_read, mem_write) is forced to 0.
- WB bypass on capture: if wb_reg_write & wb_rd_addr!=0 & wb_rd_addr==id_rsN_addr, then ex_rsN_val=wb_rd_val, else id_rsN_val. Applied independently to rs1 and rs2.
- Latency: 1 cycle from ID to EX. A load-use hazard costs exactly 1 bubble, because the held ID instruction no longer matches once the load leaves EX.
- rs addr 0 never raises a hazard and never takes the bypass.
- Reset asserted mid-stall clears all state immediately. After release, stall=0 until a new hazard occurs.

Test Plan:
- Reset: rst_n=0 mid-run with ex_valid=1 -> all ex_* read 0 and stall_cnt=0 asynchronously; after release, stall=0.
- Load-use: cycle0 ID captures lw x5 (mem_read=1, rd=5); cycle1 ID add x6,x5,x7 (use_rs1=1) -> stall=1, next edge ex_valid=0 and stall_cnt=1. The following edge captures the add with ex_rs1_addr=5, stall=0.
- No false hazard: ex holds lw to x0 while ID reads rs1=0 -> stall=0. Ex holds lw x5 while ID has use_rs2=0 and rs2=5 -> stall=0.
- Flush beats hazard: lu_hazard=1 and ex_branch_taken=1 in the same cycle -> stall=0, bubble loaded, stall_cnt unchanged.
- Hold: hold=1 for 3 cycles with changing id_* inputs -> ex_* constant and stall=1 throughout. When hold drops, ID is captured on the next edge.
- WB bypass: wb_reg_write=1, wb_rd=3, wb_val=0xDEADBEEF; ID rs1=3 with id_rs1_val=0x11 and rs2=3 -> ex_rs1_val=ex_rs2_val=0xDEADBEEF. With wb_rd=0, ex_rs1_val=0x11.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands/control for EX, inserts
// load-use bubbles, honours branch flush and downstream hold, bypasses WB writes.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [XLEN-1:0]  id_rs1_val,
  input  logic [XLEN-1:0]  id_rs2_val,
  input  logic [4:0]       id_rd_addr,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic [3:0]       id_alu_op,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_rd_addr,
  input  logic [XLEN-1:0]  wb_rd_val,
  input  logic             ex_branch_taken,
  input  logic             hold,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1_addr,
  output logic [4:0]       ex_rs2_addr,
  output logic [XLEN-1:0]  ex_rs1_val,
  output logic [XLEN-1:0]  ex_rs2_val,
  output logic [4:0]       ex_rd_addr,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic [3:0]       ex_alu_op,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rd_addr;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [3:0]      alu_op;
  } ex_regs_t;

  ex_regs_t        ex_q, ex_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lu_hazard;
  logic rs1_bypass, rs2_bypass;

  // A load in EX whose rd (non-zero) is read by the ID instruction.
  assign lu_hazard = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd_addr != 5'd0) &
                     ((id_use_rs1 & (id_rs1_addr == ex_q.rd_addr)) |
                      (id_use_rs2 & (id_rs2_addr == ex_q.rd_addr)));

  assign rs1_bypass = wb_reg_write & (wb_rd_addr != 5'd0) & (wb_rd_addr == id_rs1_addr);
  assign rs2_bypass = wb_reg_write & (wb_rd_addr != 5'd0) & (wb_rd_addr == id_rs2_addr);

  // A flush kills the younger instruction, so its hazard must not freeze IF/ID.
  assign stall = hold | (~ex_branch_taken & lu_hazard);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    ex_d        = ex_q;
    stall_cnt_d = stall_cnt_q;
    if (hold) begin
      ex_d = ex_q;
    end else if (ex_branch_taken) begin
      ex_d = '0;
    end else if (lu_hazard) begin
      ex_d = '0;
      if (stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end else begin
      ex_d.valid     = id_valid;
      ex_d.pc        = id_pc;
      ex_d.imm       = id_imm;
      ex_d.rs1_addr  = id_rs1_addr;
      ex_d.rs2_addr  = id_rs2_addr;
      ex_d.rs1_val   = rs1_bypass ? wb_rd_val : id_rs1_val;
      ex_d.rs2_val   = rs2_bypass ? wb_rd_val : id_rs2_val;
      ex_d.rd_addr   = id_rd_addr;
      ex_d.reg_write = id_valid & id_reg_write;
      ex_d.mem_read  = id_valid & id_mem_read;
      ex_d.mem_write = id_valid & id_mem_write;
      ex_d.alu_op    = id_alu_op;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_imm       = ex_q.imm;
  assign ex_rs1_addr  = ex_q.rs1_addr;
  assign ex_rs2_addr  = ex_q.rs2_addr;
  assign ex_rs1_val   = ex_q.rs1_val;
  assign ex_rs2_val   = ex_q.rs2_val;
  assign ex_rd_addr   = ex_q.rd_addr;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_alu_op    = ex_q.alu_op;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios with literal
// expectations, then random traffic compared every cycle against a model.
module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, id_mem_write;
  logic [XLEN-1:0]  id_pc, id_imm, id_rs1_val, id_rs2_val, wb_rd_val;
  logic [4:0]       id_rs1_addr, id_rs2_addr, id_rd_addr, wb_rd_addr;
  logic [3:0]       id_alu_op;
  logic             wb_reg_write, ex_branch_taken, hold;
  logic             ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, stall;
  logic [XLEN-1:0]  ex_pc, ex_imm, ex_rs1_val, ex_rs2_val;
  logic [4:0]       ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [3:0]       ex_alu_op;
  logic [CNT_W-1:0] stall_cnt;

  int n_pass  = 0;
  int n_total = 0;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_alu_op(id_alu_op),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_rd_val(wb_rd_val),
    .ex_branch_taken(ex_branch_taken), .hold(hold),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_alu_op(ex_alu_op),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // The model describes what EX must contain: an instruction (or nothing), as
  // the pipeline rules dictate, plus a count of load-use bubbles.
  typedef struct {
    bit        valid;
    bit [31:0] pc, imm, rs1v, rs2v;
    bit [4:0]  rs1a, rs2a, rd;
    bit        rw, mr, mw;
    bit [3:0]  op;
  } ex_model_t;

  ex_model_t m_ex;
  int        m_cnt;

  function automatic bit model_depends_on_load();
    if (!id_valid || !m_ex.valid || !m_ex.mr || m_ex.rd == 0) return 1'b0;
    return (id_use_rs1 && id_rs1_addr == m_ex.rd) || (id_use_rs2 && id_rs2_addr == m_ex.rd);
  endfunction

  function automatic bit [31:0] reg_read(input bit [4:0] a, input bit [31:0] rf_val);
    if (wb_reg_write && wb_rd_addr != 0 && wb_rd_addr == a) return wb_rd_val;
    return rf_val;
  endfunction

  function automatic bit model_stall();
    if (hold) return 1'b1;
    if (ex_branch_taken) return 1'b0;
    return model_depends_on_load();
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex  = '{default: 0};
      m_cnt = 0;
    end else if (hold) begin
      // frozen
    end else if (ex_branch_taken) begin
      m_ex = '{default: 0};
    end else if (model_depends_on_load()) begin
      m_ex  = '{default: 0};
      m_cnt = (m_cnt < (1 << CNT_W) - 1) ? m_cnt + 1 : m_cnt;
    end else begin
      m_ex.valid = id_valid;
      m_ex.pc    = id_pc;
      m_ex.imm   = id_imm;
      m_ex.rs1a  = id_rs1_addr;
      m_ex.rs2a  = id_rs2_addr;
      m_ex.rs1v  = reg_read(id_rs1_addr, id_rs1_val);
      m_ex.rs2v  = reg_read(id_rs2_addr, id_rs2_val);
      m_ex.rd    = id_rd_addr;
      m_ex.rw    = id_valid && id_reg_write;
      m_ex.mr    = id_valid && id_mem_read;
      m_ex.mw    = id_valid && id_mem_write;
      m_ex.op    = id_alu_op;
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    check("cmp_ex_valid",  ex_valid,     m_ex.valid);
    check("cmp_ex_pc",     ex_pc,        m_ex.pc);
    check("cmp_ex_imm",    ex_imm,       m_ex.imm);
    check("cmp_ex_rs1a",   ex_rs1_addr,  m_ex.rs1a);
    check("cmp_ex_rs2a",   ex_rs2_addr,  m_ex.rs2a);
    check("cmp_ex_rs1v",   ex_rs1_val,   m_ex.rs1v);
    check("cmp_ex_rs2v",   ex_rs2_val,   m_ex.rs2v);
    check("cmp_ex_rd",     ex_rd_addr,   m_ex.rd);
    check("cmp_ex_rw",     ex_reg_write, m_ex.rw);
    check("cmp_ex_mr",     ex_mem_read,  m_ex.mr);
    check("cmp_ex_mw",     ex_mem_write, m_ex.mw);
    check("cmp_ex_op",     ex_alu_op,    m_ex.op);
    check("cmp_stall",     stall,        model_stall());
    check("cmp_stall_cnt", stall_cnt,    m_cnt);
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    id_valid = 0; id_pc = '0; id_imm = '0; id_rs1_addr = '0; id_rs2_addr = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_rs1_val = '0; id_rs2_val = '0; id_rd_addr = '0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_alu_op = '0;
    wb_reg_write = 0; wb_rd_addr = '0; wb_rd_val = '0; ex_branch_taken = 0; hold = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic id_load(input logic [4:0] rd);
    idle();
    id_valid = 1; id_pc = 32'h40; id_rs1_addr = 5'd1; id_use_rs1 = 1;
    id_rd_addr = rd; id_reg_write = 1; id_mem_read = 1; id_alu_op = 4'h0;
  endtask

  task automatic id_alu(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd);
    idle();
    id_valid = 1; id_pc = 32'h44; id_rs1_addr = rs1; id_use_rs1 = u1;
    id_rs2_addr = rs2; id_use_rs2 = u2; id_rd_addr = rd; id_reg_write = 1; id_alu_op = 4'h3;
    id_rs1_val = 32'h1111; id_rs2_val = 32'h2222;
  endtask

  task automatic randomize_inputs();
    id_valid        = ($urandom_range(0, 9) != 0);
    id_pc           = $urandom;
    id_imm          = $urandom;
    id_rs1_addr     = 5'($urandom_range(0, 7));
    id_rs2_addr     = 5'($urandom_range(0, 7));
    id_use_rs1      = ($urandom_range(0, 3) != 0);
    id_use_rs2      = ($urandom_range(0, 1) != 0);
    id_rs1_val      = $urandom;
    id_rs2_val      = $urandom;
    id_rd_addr      = 5'($urandom_range(0, 7));
    id_reg_write    = ($urandom_range(0, 1) != 0);
    id_mem_read     = ($urandom_range(0, 2) == 0);
    id_mem_write    = ($urandom_range(0, 4) == 0);
    id_alu_op       = 4'($urandom_range(0, 15));
    wb_reg_write    = ($urandom_range(0, 1) != 0);
    wb_rd_addr      = 5'($urandom_range(0, 7));
    wb_rd_val       = $urandom;
    ex_branch_taken = ($urandom_range(0, 6) == 0);
    hold            = ($urandom_range(0, 6) == 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    idle();
    #1 rst_n = 0;
    #1;
    check("reset_ex_valid", ex_valid, 1'b0);
    check("reset_stall_cnt", stall_cnt, '0);
    #10 rst_n = 1;
    tick();

    // Load-use: lw x5 then add x6,x5,x7 costs exactly one bubble.
    id_load(5'd5);
    tick();
    check("lu_ex_is_load", ex_mem_read, 1'b1);
    id_alu(5'd5, 1, 5'd7, 1, 5'd6);
    #1 check("lu_stall", stall, 1'b1);
    tick();
    check("lu_bubble_valid", ex_valid, 1'b0);
    check("lu_bubble_rd", ex_rd_addr, 5'd0);
    check("lu_cnt_1", stall_cnt, 4'd1);
    check("lu_stall_after", stall, 1'b0);
    tick();
    check("lu_capture_valid", ex_valid, 1'b1);
    check("lu_capture_rs1", ex_rs1_addr, 5'd5);
    check("lu_capture_rd", ex_rd_addr, 5'd6);

    // No false hazard: load to x0, and rs2 not used.
    id_load(5'd0);
    tick();
    id_alu(5'd0, 1, 5'd0, 1, 5'd9);
    #1 check("nofalse_x0", stall, 1'b0);
    id_load(5'd5);
    tick();
    id_alu(5'd2, 1, 5'd5, 0, 5'd9);
    #1 check("nofalse_rs2_unused", stall, 1'b0);

    // Flush beats hazard.
    id_load(5'd5);
    tick();
    id_alu(5'd5, 1, 5'd0, 0, 5'd8);
    ex_branch_taken = 1;
    #1 check("flush_stall", stall, 1'b0);
    tick();
    check("flush_bubble", ex_valid, 1'b0);
    check("flush_cnt_same", stall_cnt, 4'd1);

    // Hold three cycles with changing ID inputs.
    id_alu(5'd1, 1, 5'd2, 1, 5'd3);
    id_pc = 32'h100;
    tick();
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      id_pc = 32'h200 + 32'(i * 4);
      id_rd_addr = 5'(10 + i);
      #1 check("hold_stall", stall, 1'b1);
      tick();
      check("hold_pc", ex_pc, 32'h100);
      check("hold_rd", ex_rd_addr, 5'd3);
    end
    hold = 0;
    id_pc = 32'h300;
    tick();
    check("hold_release_pc", ex_pc, 32'h300);

    // WB bypass.
    id_alu(5'd3, 1, 5'd3, 1, 5'd4);
    id_rs1_val = 32'h11;
    wb_reg_write = 1; wb_rd_addr = 5'd3; wb_rd_val = 32'hDEADBEEF;
    tick();
    check("byp_rs1", ex_rs1_val, 32'hDEADBEEF);
    check("byp_rs2", ex_rs2_val, 32'hDEADBEEF);
    wb_rd_addr = 5'd0;
    tick();
    check("byp_x0_rs1", ex_rs1_val, 32'h11);

    // Async reset in the middle of a stall.
    id_load(5'd5);
    tick();
    id_alu(5'd5, 1, 5'd0, 0, 5'd6);
    #1 check("rst_pre_stall", stall, 1'b1);
    rst_n = 0;
    #1;
    check("rst_async_valid", ex_valid, 1'b0);
    check("rst_async_mr", ex_mem_read, 1'b0);
    check("rst_async_rd", ex_rd_addr, 5'd0);
    check("rst_async_cnt", stall_cnt, '0);
    tick();
    rst_n = 1;
    #1 check("rst_release_stall", stall, 1'b0);
    tick();
    check("rst_release_capture", ex_rd_addr, 5'd6);
    check("rst_release_cnt", stall_cnt, '0);

    // Saturation: 20 load-use pairs with a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      id_load(5'd7);
      tick();
      id_alu(5'd0, 0, 5'd7, 1, 5'd8);
      tick();
      tick();
    end
    check("sat_cnt", stall_cnt, 4'hF);

    // Random traffic checked by the compare process.
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      tick();
    end

    idle();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
